// File: rtl/led7seg_scan_scheduler_if.sv
// Digit-transfer handshake between the scan scheduler and the 74HC595 shifter.
// dat = {segment byte, digit-select byte}, qualified by vld, accepted on vld && rdy.
interface led7seg_scan_scheduler_if;
  logic [15:0] dat;
  logic        vld;
  logic        rdy;

  modport master (output dat, output vld, input rdy);
  modport slave  (input dat, input vld, output rdy);
endinterface

// File: rtl/led7seg_scan_scheduler.sv
// Paces eight BCD digits out to a 74HC595 display controller, one transfer per digit period.
// Optional leading-zero blanking is enabled by defining LED7SEG_SCAN_LZB_EN.
module led7seg_scan_scheduler #(
  parameter int unsigned REFRESH_DIV = 15625
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [31:0]                      bcd,
  input  logic                             load,
  input  logic [7:0]                       blank,
  led7seg_scan_scheduler_if.master         tx,
  output logic                             frame_done
);

  typedef enum logic [1:0] {IDLE, PACE, ISSUE} state_t;

  localparam logic [15:0] PACE_LAST = 16'(REFRESH_DIV - 1);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] dat_q, dat_d;
  logic        frame_done_q, frame_done_d;
  logic [31:0] pend_bcd_q, pend_bcd_d;
  logic [7:0]  pend_blank_q, pend_blank_d;
  logic        pend_v_q, pend_v_d;
  logic [31:0] act_bcd_q, act_bcd_d;
  logic [7:0]  act_blank_q, act_blank_d;

  logic [31:0] src_bcd;
  logic [7:0]  src_blank;
  logic [2:0]  nib_sel;
  logic [3:0]  nib;
  logic        hide;
  logic [7:0]  seg;

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    logic [7:0] s;
    case (n)
      4'd0:    s = 8'h3F;
      4'd1:    s = 8'h06;
      4'd2:    s = 8'h5B;
      4'd3:    s = 8'h4F;
      4'd4:    s = 8'h66;
      4'd5:    s = 8'h6D;
      4'd6:    s = 8'h7D;
      4'd7:    s = 8'h07;
      4'd8:    s = 8'h7F;
      4'd9:    s = 8'h6F;
      default: s = 8'h00;
    endcase
    return s;
  endfunction

`ifdef LED7SEG_SCAN_LZB_EN
  // Digit i is a leading zero when it and every more-significant nibble are 0; digit 7 always shows.
  function automatic logic lead_zero(input logic [31:0] b, input logic [2:0] i);
    logic z;
    z = (i != 3'd7);
    for (int k = 0; k < 7; k++) begin
      if (k <= int'(i) && b[31 - 4*k -: 4] != 4'd0) z = 1'b0;
    end
    return z;
  endfunction
`endif

  // Digit 0 takes a coincident load first, then a pending one, so a frame never mixes loads.
  always_comb begin
    src_bcd   = act_bcd_q;
    src_blank = act_blank_q;
    if (idx_q == 3'd0) begin
      if (load) begin
        src_bcd   = bcd;
        src_blank = blank;
      end else if (pend_v_q) begin
        src_bcd   = pend_bcd_q;
        src_blank = pend_blank_q;
      end
    end
    nib_sel = 3'd7 - idx_q;
    nib     = src_bcd[{nib_sel, 2'b00} +: 4];
    hide    = src_blank[idx_q];
`ifdef LED7SEG_SCAN_LZB_EN
    hide    = hide | lead_zero(src_bcd, idx_q);
`endif
    seg     = hide ? 8'h00 : seg_decode(nib);
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    dat_d        = dat_q;
    frame_done_d = 1'b0;
    pend_bcd_d   = pend_bcd_q;
    pend_blank_d = pend_blank_q;
    pend_v_d     = pend_v_q;
    act_bcd_d    = act_bcd_q;
    act_blank_d  = act_blank_q;

    if (load) begin
      pend_bcd_d   = bcd;
      pend_blank_d = blank;
      pend_v_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        idx_d = 3'd0;
        if (en) begin
          state_d = PACE;
          cnt_d   = 16'd0;
        end
      end
      PACE: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = 3'd0;
        end else if (cnt_q == PACE_LAST) begin
          state_d = ISSUE;
          dat_d   = {seg, 8'h01 << idx_q};
          if (idx_q == 3'd0) begin
            act_bcd_d   = src_bcd;
            act_blank_d = src_blank;
            pend_v_d    = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ISSUE: begin
        // en is not sampled until the transfer completes, so vld never drops early.
        if (tx.rdy) begin
          idx_d        = idx_q + 3'd1;
          cnt_d        = 16'd0;
          frame_done_d = (idx_q == 3'd7);
          state_d      = en ? PACE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      cnt_q        <= 16'd0;
      dat_q        <= 16'h0000;
      frame_done_q <= 1'b0;
      pend_bcd_q   <= 32'd0;
      pend_blank_q <= 8'd0;
      pend_v_q     <= 1'b0;
      act_bcd_q    <= 32'd0;
      act_blank_q  <= 8'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      dat_q        <= dat_d;
      frame_done_q <= frame_done_d;
      pend_bcd_q   <= pend_bcd_d;
      pend_blank_q <= pend_blank_d;
      pend_v_q     <= pend_v_d;
      act_bcd_q    <= act_bcd_d;
      act_blank_q  <= act_blank_d;
    end
  end

  assign tx.dat     = dat_q;
  assign tx.vld     = (state_q == ISSUE);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led7seg_scan_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a frame-level display model.
module tb_led7seg_scan_scheduler;

  localparam int RD = 4;
  localparam logic [7:0] SEG_TAB [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [31:0] bcd = 32'd0;
  logic [7:0]  blank = 8'd0;
  logic        frame_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  led7seg_scan_scheduler_if bus ();

  led7seg_scan_scheduler #(.REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .bcd        (bcd),
    .load       (load),
    .blank      (blank),
    .tx         (bus.master),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Expected word for digit i of a displayed value: table lookup, arithmetic leading-zero test.
  function automatic logic [15:0] ref_dat(input logic [31:0] b, input logic [7:0] bl, input int i);
    logic [3:0] nib;
    logic       hide;
    nib  = b[31 - 4*i -: 4];
    hide = bl[i];
`ifdef LED7SEG_SCAN_LZB_EN
    if (i < 7 && (b >> (28 - 4*i)) == 32'd0) hide = 1'b1;
`endif
    return {hide ? 8'h00 : SEG_TAB[nib], 8'(1 << i)};
  endfunction

  // Reference model state: what the display should show, tracked per transfer.
  logic [31:0] m_pend_bcd, m_act_bcd;
  logic [7:0]  m_pend_blank, m_act_blank;
  logic        m_pend_v;
  int          m_idx, prev_idx, last_xfer_cyc;
  logic        prev_vld, prev_xfer, gap_valid, exp_fd, xfer;
  logic [15:0] cur_exp;
  logic [15:0] xfer_q [$];

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      m_pend_bcd = 0; m_pend_blank = 0; m_pend_v = 0;
      m_act_bcd = 0; m_act_blank = 0; m_idx = 0; prev_idx = 0;
      prev_vld = 0; prev_xfer = 0; gap_valid = 0; cur_exp = 0;
    end else begin
      exp_fd = prev_xfer && (prev_idx == 7);
      checks++;
      if (frame_done !== exp_fd) begin
        errors++;
        $display("FAIL mon_frame_done cyc=%0d got=%b want=%b", cyc, frame_done, exp_fd);
      end
      if (bus.vld) begin
        if (!(prev_vld && !prev_xfer)) begin
          if (m_idx == 0 && m_pend_v) begin
            m_act_bcd = m_pend_bcd; m_act_blank = m_pend_blank; m_pend_v = 0;
          end
          cur_exp = ref_dat(m_act_bcd, m_act_blank, m_idx);
          checks++;
          if (bus.dat !== cur_exp) begin
            errors++;
            $display("FAIL mon_dat cyc=%0d digit=%0d got=%h want=%h", cyc, m_idx, bus.dat, cur_exp);
          end
          if (gap_valid) begin
            checks++;
            if (cyc - last_xfer_cyc != RD + 1) begin
              errors++;
              $display("FAIL mon_period cyc=%0d got=%0d want=%0d", cyc, cyc - last_xfer_cyc, RD + 1);
            end
          end
        end else begin
          checks++;
          if (bus.dat !== cur_exp) begin
            errors++;
            $display("FAIL mon_hold cyc=%0d got=%h want=%h", cyc, bus.dat, cur_exp);
          end
        end
      end else if (prev_vld && !prev_xfer) begin
        checks++;
        errors++;
        $display("FAIL mon_vld_drop cyc=%0d got=0 want=1", cyc);
      end
      xfer = bus.vld && bus.rdy;
      if (xfer) begin
        xfer_q.push_back(bus.dat);
        $display("xfer cyc=%0d digit=%0d dat=%h", cyc, m_idx, bus.dat);
        prev_idx = m_idx;
        m_idx = (m_idx + 1) % 8;
        last_xfer_cyc = cyc;
        gap_valid = en;
        if (!en) m_idx = 0;
      end
      if (!en) gap_valid = 0;
      if (!en && !bus.vld) m_idx = 0;
      if (load) begin
        m_pend_bcd = bcd; m_pend_blank = blank; m_pend_v = 1;
      end
      prev_vld = bus.vld;
      prev_xfer = xfer;
    end
  end

  task automatic wait_xfers(input int n, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (xfer_q.size() >= n) begin ok = 1; break; end
    end
  endtask

  task automatic wait_sel(input logic [7:0] sel, input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (bus.vld && bus.dat[7:0] == sel) begin ok = 1; break; end
    end
  endtask

  task automatic pulse_load(input logic [31:0] v, input logic [7:0] bl);
    bcd = v; blank = bl; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b0; bus.rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.vld !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b want=0", bus.vld); end
    checks++; if (bus.dat !== 16'h0000) begin errors++; $display("FAIL reset_dat got=%h want=0000", bus.dat); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b want=0", frame_done); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    logic [15:0] exp [8];
    bit ok;
    exp = '{16'h3F01, 16'h0602, 16'h5B04, 16'h4F08, 16'h6610, 16'h6D20, 16'h7D40, 16'h0780};
`ifdef LED7SEG_SCAN_LZB_EN
    exp[0] = 16'h0001;
`endif
    xfer_q.delete();
    pulse_load(32'h01234567, 8'h00);
    bus.rdy = 1'b1; en = 1'b1;
    wait_xfers(8, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got=%0d want=8", xfer_q.size()); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL basic_fd got=%b want=1", frame_done); end
    for (int i = 0; i < 8 && i < xfer_q.size(); i++) begin
      checks++;
      if (xfer_q[i] !== exp[i]) begin errors++; $display("FAIL basic_dat%0d got=%h want=%h", i, xfer_q[i], exp[i]); end
    end
  endtask

  task automatic test_stall;
    bit ok;
    wait_sel(8'h08, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_sync got=0 want=1"); end
    bus.rdy = 1'b0;
    xfer_q.delete();
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.vld !== 1'b1 || bus.dat !== 16'h4F08) begin
        errors++; $display("FAIL stall_hold%0d got=%b/%h want=1/4F08", k, bus.vld, bus.dat);
      end
    end
    bus.rdy = 1'b1;
    wait_xfers(2, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got=%0d want=2", xfer_q.size()); end
    checks++; if (xfer_q.size() < 2 || xfer_q[0] !== 16'h4F08 || xfer_q[1] !== 16'h6610) begin
      errors++; $display("FAIL stall_next got=%p want=4F08,6610", xfer_q);
    end
  endtask

  task automatic test_last_wins;
    bit ok;
    logic [15:0] want;
    pulse_load(32'h11111111, 8'h00);
    wait_sel(8'h10, 200, ok);
    while (ok && bus.dat !== 16'h0610) wait_sel(8'h10, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lw_sync got=0 want=1"); end
    xfer_q.delete();
    pulse_load(32'h11111111, 8'h00);
    pulse_load(32'h22222222, 8'h00);
    wait_xfers(12, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL lw_timeout got=%0d want=12", xfer_q.size()); end
    for (int i = 0; i < 12 && i < xfer_q.size(); i++) begin
      want = (i < 4) ? {8'h06, 8'(1 << (i + 4))} : {8'h5B, 8'(1 << (i - 4))};
      checks++;
      if (xfer_q[i] !== want) begin errors++; $display("FAIL lw_dat%0d got=%h want=%h", i, xfer_q[i], want); end
    end
  endtask

  task automatic test_en_drop;
    bit ok;
    wait_sel(8'h80, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL en_sync got=0 want=1"); end
    bus.rdy = 1'b0; en = 1'b0;
    xfer_q.delete();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.vld !== 1'b1 || bus.dat !== 16'h5B80) begin
        errors++; $display("FAIL en_hold%0d got=%b/%h want=1/5B80", k, bus.vld, bus.dat);
      end
    end
    bus.rdy = 1'b1;
    @(posedge clk); #1;
    checks++; if (frame_done !== 1'b1 || bus.vld !== 1'b0) begin
      errors++; $display("FAIL en_done got=fd%b/vld%b want=fd1/vld0", frame_done, bus.vld);
    end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.vld !== 1'b0 || frame_done !== 1'b0 || xfer_q.size() != 1) begin
      errors++; $display("FAIL en_idle got=vld%b/fd%b/n%0d want=vld0/fd0/n1", bus.vld, frame_done, xfer_q.size());
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [15:0] want;
    want = 16'h3F01;
`ifdef LED7SEG_SCAN_LZB_EN
    want = 16'h0001;
`endif
    en = 1'b1; bus.rdy = 1'b1;
    wait_sel(8'h04, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rm_sync got=0 want=1"); end
    bus.rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (bus.vld !== 1'b0 || bus.dat !== 16'h0000) begin
      errors++; $display("FAIL rm_drop got=%b/%h want=0/0000", bus.vld, bus.dat);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1; bus.rdy = 1'b1;
    xfer_q.delete();
    wait_xfers(1, 40, ok);
    checks++; if (!ok || xfer_q[0] !== want) begin
      errors++; $display("FAIL rm_first got=%h want=%h", ok ? xfer_q[0] : 16'hxxxx, want);
    end
  endtask

  task automatic test_blank;
    bit ok;
    logic [31:0] v;
    logic [7:0]  bl;
    for (int it = 0; it < 3; it++) begin
      v  = (it == 0) ? 32'h00000000 : $urandom;
      bl = (it == 0) ? 8'h80 : 8'($urandom & $urandom);
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(posedge clk); #1;
        ok = frame_done;
      end
      checks++; if (!ok) begin errors++; $display("FAIL blank_sync%0d got=0 want=1", it); end
      xfer_q.delete();
      pulse_load(v, bl);
      wait_xfers(8, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_timeout%0d got=%0d want=8", it, xfer_q.size()); end
      for (int i = 0; i < 8 && i < xfer_q.size(); i++) begin
        checks++;
        if (xfer_q[i] !== ref_dat(v, bl, i)) begin
          errors++; $display("FAIL blank%0d_d%0d got=%h want=%h", it, i, xfer_q[i], ref_dat(v, bl, i));
        end
      end
    end
  endtask

  task automatic test_random;
    xfer_q.delete();
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      bus.rdy = ($urandom % 4) != 0;
      en      = ($urandom % 60) != 0;
      load    = ($urandom % 40) == 0;
      if (load) begin
        bcd   = $urandom;
        blank = (($urandom % 4) == 0) ? 8'($urandom) : 8'h00;
      end
    end
    @(posedge clk); #1;
    load = 1'b0;
    checks++; if (xfer_q.size() < 20) begin errors++; $display("FAIL random_progress got=%0d want>=20", xfer_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_last_wins();
    test_en_drop();
    test_reset_mid();
    test_blank();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led7seg_scan_scheduler.md
LED7SEG_SCAN_SCHEDULER -- requirements
Module: led7seg_scan_scheduler

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 15625, meaning pacing cycles between digit transfers (legal range 1..65535).
REQ-002 The block SHALL have port clk, input, 1, the single system clock; all logic on rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port en, input, 1, meaning scanning enable.
REQ-005 The block SHALL have port bcd, input, 32, meaning 8 BCD nibbles; digit 0 = bcd[31:28] (most significant), digit 7 = bcd[3:0].
REQ-006 The block SHALL have port load, input, 1, a one-cycle strobe that captures bcd and blank.
REQ-007 The block SHALL have port blank, input, 8, a per-digit force-blank mask; bit i = digit i.
REQ-008 The block SHALL have port dat, output, 16, meaning {segment byte, digit-select byte} to the 74HC595 controller.
REQ-009 The block SHALL have port vld, output, 1, meaning dat valid.
REQ-010 The block SHALL have port rdy, input, 1, meaning the controller accepts dat.
REQ-011 The block SHALL have port frame_done, output, 1, a one-cycle pulse after digit 7 transfers.

Function
REQ-012 Segment byte SHALL be {dp,g,f,e,d,c,b,a}, 1 = lit, dp always 0; codes 0-9 = 3F,06,5B,4F,66,6D,7D,07,7F,6F; nibbles A-F and blanked digits = 00.
REQ-013 Digit-select byte SHALL be one-hot 8'h01 << i for digit i.
REQ-014 load SHALL write bcd/blank into a pending buffer and set pending flag; a later load before use overwrites it (last wins).
REQ-015 Pending buffer SHALL copy into the active buffer only when issuing digit 0, clearing the flag, so a frame never mixes two loads.
REQ-016 FSM states: IDLE, PACE, ISSUE.
REQ-017 IDLE: vld=0, index=0; en=1 -> PACE with pace counter cleared.
REQ-018 PACE: counter increments each cycle; at REFRESH_DIV-1 -> ISSUE, dat registered for current index; en=0 in PACE -> IDLE.
REQ-019 ISSUE: vld=1, dat held stable until vld&&rdy; on transfer index wraps 7->0, counter cleared, -> PACE (or IDLE if en=0).
REQ-020 en deassertion during ISSUE SHALL NOT drop vld; transfer completes first.
REQ-021 rdy asserted outside ISSUE SHALL be ignored; rdy stall is unbounded and SHALL NOT advance index.
REQ-022 frame_done SHALL pulse the cycle after the digit-7 transfer, including when en fell during that transfer.
REQ-023 Digit period SHALL be REFRESH_DIV cycles of PACE plus ISSUE duration (>=1 cycle).
REQ-024 load coincident with digit-0 issue SHALL be applied to that frame.

Reset
REQ-025 On rst low, asynchronously: state=IDLE, dat=16'h0000, vld=0, frame_done=0, index=0, counter=0, both buffers and pending flag cleared.
REQ-026 Reset mid-transfer SHALL drop vld immediately; after release the first issued digit is 0 with blank active content (segment 3F).

Configuration
REQ-027 Macro LED7SEG_SCAN_LZB_EN defined: leading-zero blanking, digit i (0..6) shows 00 when its nibble and all more-significant nibbles are 0; digit 7 never auto-blanked; blank mask ORed on top.
REQ-028 Macro undefined: every digit decoded per REQ-012 except blank mask; no blanking logic present.

Verification
REQ-029 REFRESH_DIV=4, rdy=1, en=1, load bcd=32'h01234567 -> dat sequence 3F01,0602,5B04,4F08,6610,6D20,7D40,0780 (LZB_EN: first 0001), frame_done after 0780, 5 cycles per digit.
REQ-030 rdy held 0 for 20 cycles during digit 3 -> vld=1, dat=4F08 constant, no index advance; rdy=1 -> 6610 next.
REQ-031 load 32'h11111111 while issuing digit 4, then load 32'h22222222 before frame end -> remainder of frame shows 06; next frame all 5B.
REQ-032 en=0 during ISSUE of digit 7 with rdy low 3 cycles -> vld held until rdy, frame_done pulses, state IDLE, vld=0.
REQ-033 rst low during ISSUE of digit 2 -> vld=0, dat=0000 same cycle; after release first dat=3F01.
REQ-034 LZB_EN, bcd=32'h00000000, blank=8'h80 -> all eight digits segment 00.
